// File: rtl/nn_data_requester.sv
// Frame sequencer for the get_data/which_data/busy fetch port: image set first, then one
// coefficient set per layer, each handed to the compute engine before the next fetch.
module nn_data_requester #(
  parameter int LBITS      = 2,
  parameter int NLAYERS    = 3,
  parameter int TIMEOUT    = 1048576,
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  get_data,
  output logic [LBITS-1:0]      which_data,
  input  logic                  busy,
  output logic                  data_valid,
  output logic [LBITS-1:0]      data_sel,
  output logic                  layer_start,
  output logic [LBITS-1:0]      layer_idx,
  input  logic                  layer_done,
  output logic                  frame_done,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  error,
  output logic                  idle,
  output logic [2:0]            dbg_state
);

  // Handshake: get_data stays high in REQ until busy=1 is sampled; the set is then
  // considered on the bus once busy=0 is sampled, marked by a one-cycle data_valid.
  localparam int                CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]     TLAST    = CW'(TIMEOUT - 1);
  localparam logic [LBITS-1:0]  LAST_SET = LBITS'(NLAYERS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_CSTART  = 3'd4,
    S_CWAIT   = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_tcnt;
  logic [LBITS-1:0]        r_which;
  logic [LBITS-1:0]        w_which_next;
  logic                    w_tmo;
  logic                    w_frame_end;

  logic                    r_get_data;
  logic                    r_data_valid;
  logic [LBITS-1:0]        r_data_sel;
  logic                    r_layer_start;
  logic [LBITS-1:0]        r_layer_idx;
  logic                    r_frame_done;
  logic [FRAME_BITS-1:0]   r_frame_count;
  logic                    r_error;
  logic                    r_idle;

  always_comb begin
    w_next       = r_state;
    w_which_next = r_which;
    w_tmo        = (r_tcnt == TLAST);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next       = S_REQ;
          w_which_next = '0;
        end
      end
      S_REQ: begin
        if (busy)       w_next = S_WAIT;
        else if (w_tmo) w_next = S_ERROR;
      end
      S_WAIT: begin
        if (!busy)      w_next = S_DELIVER;
        else if (w_tmo) w_next = S_ERROR;
      end
      S_DELIVER: begin
        if (r_which == '0) begin
          w_next       = S_REQ;
          w_which_next = LBITS'(1);
        end else begin
          w_next = S_CSTART;
        end
      end
      S_CSTART: w_next = S_CWAIT;
      S_CWAIT: begin
        if (layer_done) begin
          if (r_which < LAST_SET) begin
            w_next       = S_REQ;
            w_which_next = r_which + LBITS'(1);
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
    w_frame_end = (r_state == S_CWAIT) && (w_next == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_which <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_which <= w_which_next;
      // Any state change restarts the wait budget; it only matters in REQ and WAIT.
      if (w_next != r_state)   r_tcnt <= '0;
      else if (r_tcnt != TLAST) r_tcnt <= r_tcnt + CW'(1);
    end
  end

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_get_data    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_sel    <= '0;
      r_layer_start <= 1'b0;
      r_layer_idx   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_error       <= 1'b0;
      r_idle        <= 1'b1;
    end else begin
      r_get_data    <= (w_next == S_REQ);
      r_data_valid  <= (w_next == S_DELIVER);
      r_layer_start <= (w_next == S_CSTART);
      r_frame_done  <= w_frame_end;
      r_error       <= (w_next == S_ERROR);
      r_idle        <= (w_next == S_IDLE);
      if (w_next == S_DELIVER) r_data_sel <= r_which;
      if (w_next == S_CSTART)  r_layer_idx <= r_which - LBITS'(1);
      if (w_frame_end)         r_frame_count <= r_frame_count + FRAME_BITS'(1);
    end
  end

  assign get_data    = r_get_data;
  assign which_data  = r_which;
  assign data_valid  = r_data_valid;
  assign data_sel    = r_data_sel;
  assign layer_start = r_layer_start;
  assign layer_idx   = r_layer_idx;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign error       = r_error;
  assign idle        = r_idle;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nn_data_requester.sv
// Bench for nn_data_requester: a directed per-cycle vector table, randomized frames checked
// against a transaction-level model, and timeout/reset sequences on a short-timeout instance.
module tb_nn_data_requester;
  localparam int LB = 2;
  localparam int NL = 3;
  localparam int DC = -1;

  logic clk = 1'b0;
  logic reset, start, busy, layer_done;

  logic          a_gd, a_dv, a_ls, a_fd, a_er, a_id;
  logic [LB-1:0] a_wd, a_ds, a_li;
  logic [15:0]   a_fc;
  logic [2:0]    a_st;
  logic          b_gd, b_dv, b_ls, b_fd, b_er, b_id;
  logic [LB-1:0] b_wd, b_ds, b_li;
  logic [1:0]    b_fc;
  logic [2:0]    b_st;

  always #5 clk = ~clk;

  nn_data_requester #(.LBITS(LB), .NLAYERS(NL)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .get_data(a_gd), .which_data(a_wd),
    .busy(busy), .data_valid(a_dv), .data_sel(a_ds), .layer_start(a_ls),
    .layer_idx(a_li), .layer_done(layer_done), .frame_done(a_fd), .frame_count(a_fc),
    .error(a_er), .idle(a_id), .dbg_state(a_st)
  );

  nn_data_requester #(.LBITS(LB), .NLAYERS(NL), .TIMEOUT(16), .FRAME_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .get_data(b_gd), .which_data(b_wd),
    .busy(busy), .data_valid(b_dv), .data_sel(b_ds), .layer_start(b_ls),
    .layer_idx(b_li), .layer_done(layer_done), .frame_done(b_fd), .frame_count(b_fc),
    .error(b_er), .idle(b_id), .dbg_state(b_st)
  );

  typedef struct {
    logic st, bz, ld;
    int gd, wd, dv, ds, ls, li, fd, fc, idl;
  } vec_t;

  vec_t          tbl[$];
  logic [LB-1:0] exp_q[$];
  logic [LB-1:0] lay_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            frames = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    if (exp < 0) return;
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [31:0] a, input logic [31:0] b, input int exp);
    chk({"a.", name}, a, exp);
    chk({"b.", name}, b, exp);
  endtask

  task automatic check_reset();
    chk2("rst_get_data",    32'(a_gd), 32'(b_gd), 0);
    chk2("rst_which_data",  32'(a_wd), 32'(b_wd), 0);
    chk2("rst_data_valid",  32'(a_dv), 32'(b_dv), 0);
    chk2("rst_data_sel",    32'(a_ds), 32'(b_ds), 0);
    chk2("rst_layer_start", 32'(a_ls), 32'(b_ls), 0);
    chk2("rst_layer_idx",   32'(a_li), 32'(b_li), 0);
    chk2("rst_frame_done",  32'(a_fd), 32'(b_fd), 0);
    chk2("rst_frame_count", 32'(a_fc), 32'(b_fc), 0);
    chk2("rst_error",       32'(a_er), 32'(b_er), 0);
    chk2("rst_idle",        32'(a_id), 32'(b_id), 1);
  endtask

  function automatic vec_t mk(logic st, logic bz, logic ld, int gd, int wd, int dv, int ds,
                              int ls, int li, int fd, int fc, int idl);
    vec_t v;
    v.st = st; v.bz = bz; v.ld = ld; v.gd = gd; v.wd = wd; v.dv = dv; v.ds = ds;
    v.ls = ls; v.li = li; v.fd = fd; v.fc = fc; v.idl = idl;
    return v;
  endfunction

  // Bus side of one fetch: busy=0 for d1 REQ edges, then busy=1 for h edges, then 0.
  task automatic fetch(input int d1, input int h);
    logic [LB-1:0] e;
    for (int i = 0; i < d1; i++) begin
      busy = 1'b0; start = 1'($urandom_range(0, 1)); layer_done = 1'($urandom_range(0, 1));
      tick();
      chk2("req_hold_gd", 32'(a_gd), 32'(b_gd), 1);
    end
    busy = 1'b1; start = 1'($urandom_range(0, 1));
    tick();
    chk2("busy_ack_gd", 32'(a_gd), 32'(b_gd), 0);
    for (int i = 1; i < h; i++) begin
      tick();
      chk2("wait_dv", 32'(a_dv), 32'(b_dv), 0);
    end
    busy = 1'b0;
    tick();
    chk2("deliver_dv", 32'(a_dv), 32'(b_dv), 1);
    e = exp_q.pop_front();
    chk2("deliver_sel", 32'(a_ds), 32'(b_ds), int'(e));
  endtask

  task automatic run_frame(input bit fixed);
    int d1, h, c;
    logic [LB-1:0] li;
    for (int k = 0; k <= NL; k++) exp_q.push_back(LB'(k));
    for (int k = 0; k < NL; k++)  lay_q.push_back(LB'(k));
    start = 1'b1; busy = 1'($urandom_range(0, 1)); layer_done = 1'($urandom_range(0, 1));
    tick();
    chk2("start_gd", 32'(a_gd), 32'(b_gd), 1);
    chk2("start_wd", 32'(a_wd), 32'(b_wd), 0);
    chk2("start_idle", 32'(a_id), 32'(b_id), 0);
    for (int set = 0; set <= NL; set++) begin
      d1 = fixed ? 2 : int'($urandom_range(1, 6));
      h  = fixed ? 5 : int'($urandom_range(1, 8));
      c  = fixed ? 3 : int'($urandom_range(0, 5));
      fetch(d1, h);
      busy = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      layer_done = 1'($urandom_range(0, 1));
      tick();
      if (set == 0) begin
        chk2("img_next_gd", 32'(a_gd), 32'(b_gd), 1);
        chk2("img_next_wd", 32'(a_wd), 32'(b_wd), 1);
      end else begin
        li = lay_q.pop_front();
        chk2("lstart", 32'(a_ls), 32'(b_ls), 1);
        chk2("lstart_idx", 32'(a_li), 32'(b_li), int'(li));
        layer_done = 1'($urandom_range(0, 1));
        tick();
        chk2("lstart_pulse", 32'(a_ls), 32'(b_ls), 0);
        for (int i = 0; i < c; i++) begin
          layer_done = 1'b0; busy = 1'($urandom_range(0, 1));
          tick();
          chk2("cwait_gd", 32'(a_gd), 32'(b_gd), 0);
          chk2("cwait_idx", 32'(a_li), 32'(b_li), int'(li));
        end
        layer_done = 1'b1;
        tick();
        if (set < NL) begin
          chk2("next_gd", 32'(a_gd), 32'(b_gd), 1);
          chk2("next_wd", 32'(a_wd), 32'(b_wd), set + 1);
        end else begin
          frames++;
          chk2("frame_done", 32'(a_fd), 32'(b_fd), 1);
          chk2("frame_idle", 32'(a_id), 32'(b_id), 1);
          chk("a.frame_count", 32'(a_fc), frames % 65536);
          chk("b.frame_count", 32'(b_fc), frames % 4);
          chk2("frame_err", 32'(a_er), 32'(b_er), 0);
        end
      end
    end
    layer_done = 1'b0; busy = 1'b0; start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; layer_done = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check_reset();
    reset = 1'b0;

    // st bz ld | gd wd dv ds ls li fd fc idle
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, DC, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, DC, 1, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, DC, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, DC, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 2,  0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0, DC, 1, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, DC, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 0, DC, 0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 3,  0, DC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, DC, 1, 2,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, DC, 0, 2,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, DC, 0, DC, 0, DC, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, DC, 0, DC, 0, DC, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, DC, 0, DC, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; busy = tbl[i].bz; layer_done = tbl[i].ld;
      tick();
      chk2("vec_get_data",    32'(a_gd), 32'(b_gd), tbl[i].gd);
      chk2("vec_which_data",  32'(a_wd), 32'(b_wd), tbl[i].wd);
      chk2("vec_data_valid",  32'(a_dv), 32'(b_dv), tbl[i].dv);
      chk2("vec_data_sel",    32'(a_ds), 32'(b_ds), tbl[i].ds);
      chk2("vec_layer_start", 32'(a_ls), 32'(b_ls), tbl[i].ls);
      chk2("vec_layer_idx",   32'(a_li), 32'(b_li), tbl[i].li);
      chk2("vec_frame_done",  32'(a_fd), 32'(b_fd), tbl[i].fd);
      chk2("vec_frame_count", 32'(a_fc), 32'(b_fc), tbl[i].fc);
      chk2("vec_idle",        32'(a_id), 32'(b_id), tbl[i].idl);
      chk2("vec_error",       32'(a_er), 32'(b_er), 0);
    end

    reset = 1'b1; start = 1'b0; busy = 1'b0; layer_done = 1'b0;
    tick();
    check_reset();
    reset = 1'b0;

    // Five back-to-back frames; the 2-bit counter must read 1,2,3,0,1.
    frames = 0;
    for (int f = 0; f < 5; f++) run_frame(f == 0);
    tick();
    chk2("post_frame_done", 32'(a_fd), 32'(b_fd), 0);
    chk2("post_idle", 32'(a_id), 32'(b_id), 1);

    // busy never rises: b errors 16 cycles after get_data rises.
    start = 1'b1; busy = 1'b0;
    tick();
    chk2("to1_gd", 32'(a_gd), 32'(b_gd), 1);
    start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("b.to1_err_early", 32'(b_er), 0);
      chk("b.to1_gd_hold", 32'(b_gd), 1);
    end
    tick();
    chk("b.to1_err", 32'(b_er), 1);
    chk("b.to1_gd", 32'(b_gd), 0);
    chk("b.to1_idle", 32'(b_id), 0);
    chk("a.to1_no_err", 32'(a_er), 0);
    chk("a.to1_gd", 32'(a_gd), 1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; busy = 1'($urandom_range(0, 1)); layer_done = 1'($urandom_range(0, 1));
      tick();
      chk("b.err_sticky", 32'(b_er), 1);
      chk("b.err_gd", 32'(b_gd), 0);
    end
    reset = 1'b1; start = 1'b0; busy = 1'b0; layer_done = 1'b0;
    tick();
    check_reset();
    reset = 1'b0;

    // busy stuck high: b errors 16 cycles after WAIT entry.
    start = 1'b1;
    tick();
    start = 1'b0; busy = 1'b1;
    tick();
    chk2("to2_wait_gd", 32'(a_gd), 32'(b_gd), 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("b.to2_err_early", 32'(b_er), 0);
    end
    tick();
    chk("b.to2_err", 32'(b_er), 1);
    chk("b.to2_idle", 32'(b_id), 0);
    reset = 1'b1; busy = 1'b0;
    tick();
    check_reset();
    reset = 1'b0;

    // reset in the middle of WAIT abandons the fetch; next start fetches set 0.
    start = 1'b1;
    tick();
    start = 1'b0; busy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_reset();
    reset = 1'b0; busy = 1'b0; start = 1'b1;
    tick();
    chk2("mid_rst_gd", 32'(a_gd), 32'(b_gd), 1);
    chk2("mid_rst_wd", 32'(a_wd), 32'(b_wd), 0);
    start = 1'b0; busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    chk2("mid_rst_dv", 32'(a_dv), 32'(b_dv), 1);
    chk2("mid_rst_ds", 32'(a_ds), 32'(b_ds), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
